nibble_alu_seq: RTL
===================

# nibble_alu_seq

Multi-cycle sequencer that runs WIDTH-bit add, subtract, add-with-carry and compare operations through a single shared 4-bit adder, one nibble per cycle, LSB nibble first. It sits between an operand producer and a result consumer, each on a valid/ready handshake. It owns the carry chain, the operand inversion for subtraction and flag accumulation across nibbles. The 4-bit adder stays a pure combinational datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, minimum 8
- NIB (derived, not overridable), WIDTH/4, number of nibble steps per operation

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a rising edge
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 CMP
- in_c  in  1  carry-in, used by ADC only
- in_x  in  WIDTH  operand A
- in_y  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready at a rising edge
- out_s  out  WIDTH  result
- out_c  out  1  carry-out of MSB nibble (SUB/CMP: 1 = no borrow)
- zero  out  1  computed WIDTH-bit value is all zeros
- overflow  out  1  signed overflow of the WIDTH-bit operation
- negative  out  1  MSB of computed value

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE). All requests arriving outside IDLE are ignored, not queued.
- IDLE, on accept:
  - latch op, in_x, in_y
  - set nibble index idx = 0
  - set carry register: ADD 0, SUB 1, CMP 1, ADC in_c
  - set zero accumulator = 1
  - go to RUN
- RUN, each cycle:
  - A = x[4*idx+:4]; B = y nibble, bitwise inverted for SUB/CMP; Cin = carry register
  - carry register <= adder Carry
  - zero accumulator &= adder Zero
  - result nibble idx <= adder Result
  - idx increments
  - On idx == NIB-1: capture adder Overflow as overflow, Result[3] as negative, Carry as out_c, then go to DONE.
- DONE: out_valid = 1, all outputs held stable. On out_ready, go to IDLE.
- CMP: flags are updated as for SUB. out_s keeps the last non-CMP result (0 after reset), so the computed difference is discarded.
- No wrap or saturation. Results are modulo 2^WIDTH.
- Reset (any state, including mid-RUN or DONE):
  - next state IDLE
  - out_s = 0, out_c = 0, zero = 0, overflow = 0, negative = 0, out_valid = 0
  - carry register, idx and zero accumulator cleared
  - the in-flight operation is dropped and never reported
  - in_valid is ignored in any cycle where rst_n is low

## Timing
- Accept at edge T. RUN occupies edges T+1..T+NIB. out_valid is high from T+NIB onward.
- WIDTH = 16: out_valid rises 4 cycles after the accept edge.
- Minimum issue interval is NIB+2 cycles (accept, NIB steps, one DONE cycle with out_ready high).
- in_ready, out_valid and flags are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- DONE with out_ready = 1 returns to IDLE at that edge. in_ready rises the following cycle; there is no same-cycle re-accept.

## Structure
- Package nibble_alu_pkg:
  - op enum (OP_ADD, OP_SUB, OP_ADC, OP_CMP)
  - state enum (S_IDLE, S_RUN, S_DONE)
  - NIB_W = 4
- One sub-module: the team's existing 4-bit `adder` (ports Cin, A, B, Result, Carry, Zero, Overflow), instantiated once and driven from the sequencer's nibble muxes.
- Sequencer, carry/zero accumulators and result register are all in nibble_alu_seq.

## Test plan
- ADD 0x1234 + 0x0FCD → out_s 0x2201, out_c 0, zero 0, overflow 0, negative 0; out_valid exactly 4 cycles after accept.
- SUB 0x8000 − 0x0001 → out_s 0x7FFF, out_c 1, overflow 1, negative 0, zero 0.
- ADC 0xFFFF + 0x0000, in_c 1 → out_s 0x0000, out_c 1, zero 1, overflow 0.
- After the ADD above, CMP 0x0005 vs 0x0005 → out_s stays 0x2201, zero 1, out_c 1, overflow 0, negative 0.
- Backpressure: hold out_ready 0 for 10 cycles while pulsing in_valid with new operands → outputs unchanged, in_ready 0 throughout, the pulsed request is never executed.
- Reset: rst_n low on the 2nd RUN cycle → next cycle out_valid 0, all flags 0, out_s 0, in_ready 1; a fresh ADD 0x0001 + 0x0001 then returns 0x0002.

Source files
------------

// File: rtl/nibble_alu_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package nibble_alu_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_CMP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Subtraction runs as x + ~y + 1, so SUB/CMP seed the chain with 1.
    function automatic logic carry_init(op_t op, logic c);
        case (op)
            OP_SUB, OP_CMP: carry_init = 1'b1;
            OP_ADC:         carry_init = c;
            default:        carry_init = 1'b0;
        endcase
    endfunction

    function automatic logic invert_b(op_t op);
        invert_b = (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/nibble_alu_seq_if.sv
// Request/result handshake bundle between operand producer, ALU and result consumer.
interface nibble_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             in_c;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
    logic             zero;
    logic             overflow;
    logic             negative;

    modport master (
        output in_valid, op, in_c, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s, out_c, zero, overflow, negative
    );

    modport slave (
        input  in_valid, op, in_c, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s, out_c, zero, overflow, negative
    );
endinterface

// File: rtl/nibble_alu_seq_adder.sv
// Team 4-bit adder: pure combinational sum with carry, zero and signed-overflow flags.
module adder (
    input  logic       Cin,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Result,
    output logic       Carry,
    output logic       Zero,
    output logic       Overflow
);
    assign {Carry, Result} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    assign Zero            = (Result == 4'h0);
    assign Overflow        = (A[3] == B[3]) && (Result[3] != A[3]);
endmodule

// File: rtl/nibble_alu_seq.sv
// WIDTH-bit add/sub/adc/cmp sequencer that reuses one 4-bit adder, LSB nibble first.
module nibble_alu_seq
    import nibble_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    nibble_alu_seq_if.slave  bus
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_alu_seq: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t           state_q, state_d;
    op_t              op_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             zacc_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q, zero_q, ovf_q, neg_q;

    logic [NIB_W-1:0] a_nib, b_nib, sum_r;
    logic             sum_c, sum_z, sum_v;
    logic             last_step;

    assign last_step = (idx_q == IDX_W'(NIB - 1));
    assign a_nib     = x_q[idx_q*NIB_W +: NIB_W];
    assign b_nib     = invert_b(op_q) ? ~y_q[idx_q*NIB_W +: NIB_W]
                                      :  y_q[idx_q*NIB_W +: NIB_W];

    adder u_adder (
        .Cin      (carry_q),
        .A        (a_nib),
        .B        (b_nib),
        .Result   (sum_r),
        .Carry    (sum_c),
        .Zero     (sum_z),
        .Overflow (sum_v)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (last_step)     state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= op_t'(bus.op);
                        x_q     <= bus.in_x;
                        y_q     <= bus.in_y;
                        idx_q   <= '0;
                        carry_q <= carry_init(op_t'(bus.op), bus.in_c);
                        zacc_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    carry_q <= sum_c;
                    zacc_q  <= zacc_q & sum_z;
                    idx_q   <= idx_q + 1'b1;
                    // CMP only reports flags; the previous result stays visible.
                    if (op_q != OP_CMP) s_q[idx_q*NIB_W +: NIB_W] <= sum_r;
                    if (last_step) begin
                        c_q    <= sum_c;
                        zero_q <= zacc_q & sum_z;
                        ovf_q  <= sum_v;
                        neg_q  <= sum_r[NIB_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_s     = s_q;
    assign bus.out_c     = c_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;

endmodule
